// File: rtl/bank_queue_scheduler.sv
// Bank queue scheduler: row-hit-first arbitration over NUM_Q request FIFOs with a
// starvation cap on consecutive hits, round-robin among misses, and a single
// registered output stage feeding the command issue path.
module bank_queue_scheduler #(
   parameter int unsigned NUM_Q      = 4,
   parameter int unsigned ENTRY_SIZE = 32,
   parameter int unsigned ROW_BITS   = 4,
   parameter int unsigned MAX_HITS   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_Q-1:0]            q_empty,
   input  logic [NUM_Q*ROW_BITS-1:0]   q_head_row,
   input  logic [NUM_Q*ENTRY_SIZE-1:0] q_head_data,
   output logic [NUM_Q-1:0]            q_rd_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ENTRY_SIZE-1:0]       out_data,
   output logic [$clog2(NUM_Q)-1:0]    out_qid,
   output logic                        out_row_hit,
   input  logic                        close_row,
   output logic [ROW_BITS-1:0]         open_row,
   output logic                        open_valid
);

   localparam int unsigned QW  = $clog2(NUM_Q);
   localparam int unsigned HCW = $clog2(MAX_HITS + 1);

   // Output stage occupancy doubles as the FSM state
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t                  state_q;
   logic [ENTRY_SIZE-1:0]   out_data_q;
   logic [QW-1:0]           out_qid_q;
   logic                    out_row_hit_q;
   logic [ROW_BITS-1:0]     open_row_q;
   logic                    open_valid_q;
   logic [QW-1:0]           rr_ptr_q;
   logic [QW-1:0]           rr_ptr_d;
   logic [HCW-1:0]          hit_cnt_q;
   logic [HCW-1:0]          hit_cnt_d;

   logic [ROW_BITS-1:0]     row_arr  [NUM_Q];
   logic [ENTRY_SIZE-1:0]   data_arr [NUM_Q];

   logic                    stage_free;
   logic                    hits_ok;
   logic                    any_req;
   logic [QW-1:0]           scan_idx;
   logic                    hit_found;
   logic [QW-1:0]           hit_idx;
   logic                    miss_found;
   logic [QW-1:0]           miss_idx;
   logic                    grant;
   logic                    grant_hit;
   logic [QW-1:0]           grant_idx;

   // Unpack flat head buses into per-queue views
   always_comb begin
      for (int i = 0; i < NUM_Q; i++) begin
         row_arr[i]  = q_head_row[i*ROW_BITS +: ROW_BITS];
         data_arr[i] = q_head_data[i*ENTRY_SIZE +: ENTRY_SIZE];
      end
   end

   assign stage_free = (state_q == S_EMPTY) || out_ready;
   assign hits_ok    = open_valid_q && (hit_cnt_q < HCW'(MAX_HITS));
   assign any_req    = |(~q_empty);

   // Scan upward from rr_ptr (wrap is free since NUM_Q is a power of two)
   always_comb begin
      scan_idx   = '0;
      hit_found  = 1'b0;
      hit_idx    = '0;
      miss_found = 1'b0;
      miss_idx   = '0;
      for (int k = 0; k < NUM_Q; k++) begin
         scan_idx = rr_ptr_q + QW'(k);
         if (!q_empty[scan_idx]) begin
            if (!miss_found) begin
               miss_found = 1'b1;
               miss_idx   = scan_idx;
            end
            if (!hit_found && hits_ok && (row_arr[scan_idx] == open_row_q)) begin
               hit_found = 1'b1;
               hit_idx   = scan_idx;
            end
         end
      end
   end

   // Grant decision; held off during reset so no queue is popped
   always_comb begin
      grant     = rst_n && stage_free && any_req;
      grant_hit = hit_found;
      grant_idx = hit_found ? hit_idx : miss_idx;
      q_rd_en   = '0;
      if (grant) begin
         q_rd_en[grant_idx] = 1'b1;
      end
   end

   // Next pointer and hit counter for a grant
   always_comb begin
      rr_ptr_d  = grant_idx + QW'(1);
      hit_cnt_d = '0;
      if (grant_hit) begin
         hit_cnt_d = (hit_cnt_q == HCW'(MAX_HITS)) ? hit_cnt_q : hit_cnt_q + HCW'(1);
      end
   end

   // Output stage, open-row tracking and arbitration state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_EMPTY;
         out_data_q    <= '0;
         out_qid_q     <= '0;
         out_row_hit_q <= 1'b0;
         open_row_q    <= '0;
         open_valid_q  <= 1'b0;
         rr_ptr_q      <= '0;
         hit_cnt_q     <= '0;
      end else if (grant) begin
         state_q       <= S_FULL;
         out_data_q    <= data_arr[grant_idx];
         out_qid_q     <= grant_idx;
         out_row_hit_q <= grant_hit;
         open_row_q    <= row_arr[grant_idx];
         open_valid_q  <= 1'b1;
         rr_ptr_q      <= rr_ptr_d;
         hit_cnt_q     <= hit_cnt_d;
      end else begin
         if ((state_q == S_FULL) && out_ready) begin
            state_q <= S_EMPTY;
         end
         if (close_row) begin
            open_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid   = (state_q == S_FULL);
   assign out_data    = out_data_q;
   assign out_qid     = out_qid_q;
   assign out_row_hit = out_row_hit_q;
   assign open_row    = open_row_q;
   assign open_valid  = open_valid_q;

endmodule
